// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction memory controller
//   state_t    - controller state (BOOT, IDLE, LOAD)
//   NOP_INS    - instruction returned on a faulting fetch
//   BOOT_IMAGE - words written to the bottom of memory after reset
//   boot_word  - BOOT_IMAGE lookup, zero beyond the image or beyond len
package imem_pkg;

    typedef enum logic [1:0] {BOOT, IDLE, LOAD} state_t;

    localparam logic [31:0] NOP_INS = 32'h0;
    localparam int IMAGE_LEN = 6;
    localparam logic [31:0] BOOT_IMAGE [IMAGE_LEN] = '{
        32'h44010000, 32'h8C200004, 32'h00411001,
        32'h08210001, 32'h83FFFFFD, 32'h90000000
    };

    function automatic logic [31:0] boot_word(input int unsigned i, input int unsigned len);
        logic [31:0] w;
        w = NOP_INS;
        for (int k = 0; k < IMAGE_LEN; k++)
            if (i == k && i < len) w = BOOT_IMAGE[k];
        return w;
    endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: 1R1W RAM, synchronous write, registered synchronous read
//   clk, rst        - clock; rst clears only the read register, not the array
//   we_i/waddr_i/wdata_i - write port
//   re_i/raddr_i    - read enable/address; rdata_o holds when re_i is low
//   rdata_o         - read data, valid the cycle after re_i
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk)
        if (we_i) mem[waddr_i] <= wdata_i;

    always_ff @(posedge clk or posedge rst)
        if (rst) rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction memory with boot sequencer, fetch port and streaming loader
//   clk, rst (async, active-high)
//   fetch_req/fetch_addr -> fetch_valid/fetch_ins/fetch_fault one cycle later (IDLE only)
//   busy        - high in BOOT and LOAD
//   load_start/load_base - begin a load in IDLE
//   load_valid/load_data/load_last/load_ready - word stream handshake
//   load_done   - one-cycle pulse at the end of a load
//   load_overflow - sticky, set when a load runs off the top or starts out of range
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 32,
    parameter int BOOT_LEN = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_ins,
    output logic              fetch_fault,
    output logic              busy,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    state_t state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic ovf_q, ovf_d, done_q, done_d, fvalid_q, fault_q;
    logic fetch_acc, fetch_ok, load_acc, we;
    logic [DATA_W-1:0] wdata, rdata;

    assign busy       = state_q != IDLE;
    assign load_ready = state_q == LOAD;
    assign load_acc   = load_valid && load_ready;
    assign fetch_acc  = fetch_req && !busy;
    assign fetch_ok   = fetch_addr < LIMIT;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        we      = 1'b0;
        wdata   = load_data;
        case (state_q)
            BOOT: begin
                // pointer wraps to zero after the last word, ready for nothing in particular
                we      = 1'b1;
                wdata   = DATA_W'(boot_word(32'(ptr_q), BOOT_LEN));
                ptr_d   = ptr_q + 1'b1;
                state_d = ptr_q == TOP ? IDLE : BOOT;
            end
            IDLE: begin
                if (load_start) begin
                    ovf_d   = load_base >= LIMIT;
                    done_d  = load_base >= LIMIT;
                    ptr_d   = load_base[AW-1:0];
                    state_d = load_base >= LIMIT ? IDLE : LOAD;
                end
            end
            LOAD: begin
                if (load_acc) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    // last word or top of memory ends the load; the latter without last flags overflow
                    if (load_last || ptr_q == TOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        ovf_d   = !load_last;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            ptr_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            fvalid_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            fvalid_q <= fetch_acc;
            if (fetch_acc) fault_q <= !fetch_ok;
        end
    end

    imem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (ptr_q),
        .wdata_i (wdata),
        .re_i    (fetch_acc && fetch_ok),
        .raddr_i (fetch_addr[AW-1:0]),
        .rdata_o (rdata)
    );

    // a faulting fetch leaves the RAM read register alone and substitutes NOP
    assign fetch_valid   = fvalid_q;
    assign fetch_fault   = fault_q;
    assign fetch_ins     = fault_q ? DATA_W'(NOP_INS) : rdata;
    assign load_done     = done_q;
    assign load_overflow = ovf_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: scoreboard bench for imem_ctrl against an array reference model
module tb_imem_ctrl;

    localparam int DEPTH = 1024;
    localparam logic [31:0] IMG [6] = '{
        32'h44010000, 32'h8C200004, 32'h00411001,
        32'h08210001, 32'h83FFFFFD, 32'h90000000
    };

    logic clk = 0, rst = 1;
    logic fetch_req = 0, load_start = 0, load_valid = 0, load_last = 0;
    logic [31:0] fetch_addr = 0, load_base = 0, load_data = 0;
    logic fetch_valid, fetch_fault, busy, load_ready, load_done, load_overflow;
    logic [31:0] fetch_ins;

    typedef struct { logic [31:0] ins; logic fault; int due; } exp_t;
    exp_t q[$];
    logic [31:0] model [DEPTH];
    int total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BOOT_LEN(6)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_ins(fetch_ins), .fetch_fault(fetch_fault),
        .busy(busy),
        .load_start(load_start), .load_base(load_base),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .load_done(load_done), .load_overflow(load_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] a);
        exp_t e;
        e.ins   = a < DEPTH ? model[a] : 32'h0;
        e.fault = a >= DEPTH;
        e.due   = cyc + 1;
        q.push_back(e);
    endtask

    task automatic do_fetch(input logic [31:0] a);
        push_fetch(a);
        fetch_req  = 1;
        fetch_addr = a;
        tick();
        fetch_req = 0;
    endtask

    task automatic boot_wait();
        int n = 0;
        for (int k = 0; k < DEPTH; k++) model[k] = k < 6 ? IMG[k] : 32'h0;
        chk("busy after reset release", 32'(busy), 1);
        while (busy && n < 3000) begin
            fetch_req  = 1'($urandom_range(1));
            fetch_addr = $urandom_range(7);
            load_start = 1'($urandom_range(1));
            load_base  = 0;
            tick();
            n++;
        end
        fetch_req  = 0;
        load_start = 0;
        chk("boot busy cycles", n, DEPTH);
        chk("load_ready after boot", 32'(load_ready), 0);
    endtask

    task automatic do_load(input logic [31:0] base, input int n, input bit use_last,
                           input logic [31:0] seed, input bit co_fetch);
        int p;
        bit ended = 0, ovf = 0;
        logic [31:0] w;
        if (co_fetch) begin
            push_fetch(base);
            fetch_req  = 1;
            fetch_addr = base;
        end
        load_start = 1;
        load_base  = base;
        tick();
        load_start = 0;
        fetch_req  = 0;
        if (base >= DEPTH) begin
            chk("oob load_done", 32'(load_done), 1);
            chk("oob load_overflow", 32'(load_overflow), 1);
            chk("oob busy", 32'(busy), 0);
            tick();
            chk("oob load_done pulse", 32'(load_done), 0);
            return;
        end
        chk("load busy", 32'(busy), 1);
        chk("load_overflow cleared", 32'(load_overflow), 0);
        p = base;
        for (int k = 0; k < n && !ended; k++) begin
            load_valid = 0;
            repeat ($urandom_range(2)) tick();
            w = seed == 0 ? $urandom : seed + k;
            chk("load_ready", 32'(load_ready), 1);
            load_valid = 1;
            load_data  = w;
            load_last  = use_last && k == n - 1;
            tick();
            model[p] = w;
            p++;
            if (load_last || p == DEPTH) begin
                ended = 1;
                ovf = !load_last;
            end
            load_valid = 0;
            load_last  = 0;
        end
        chk("load ended", 32'(ended), 1);
        chk("load_done", 32'(load_done), 1);
        chk("busy after load", 32'(busy), 0);
        chk("load_ready after load", 32'(load_ready), 0);
        chk("load_overflow", 32'(load_overflow), 32'(ovf));
        load_valid = 1;
        load_data  = $urandom;
        tick();
        load_valid = 0;
        chk("load_done single pulse", 32'(load_done), 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("fetch_valid", 32'(fetch_valid), 1);
                chk("fetch_ins", fetch_ins, e.ins);
                chk("fetch_fault", 32'(fetch_fault), 32'(e.fault));
            end else if (fetch_valid) begin
                chk("spurious fetch_valid", 32'(fetch_valid), 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 1);
        chk("reset fetch_valid", 32'(fetch_valid), 0);
        chk("reset fetch_ins", fetch_ins, 0);
        chk("reset fetch_fault", 32'(fetch_fault), 0);
        chk("reset load_ready", 32'(load_ready), 0);
        chk("reset load_done", 32'(load_done), 0);
        chk("reset load_overflow", 32'(load_overflow), 0);
        rst = 0;
        boot_wait();

        do_fetch(0); tick();
        do_fetch(5); tick();
        do_fetch(6); tick();

        do_fetch(1024); tick();
        do_fetch(32'hFFFFFFFF); tick();
        for (int a = 0; a < 6; a++) do_fetch(a);
        tick();

        do_load(16, 3, 1, 32'hA, 0);
        do_fetch(16); do_fetch(17); do_fetch(18); tick();

        do_load(1022, 4, 0, 0, 0);
        do_fetch(1022); do_fetch(1023); tick();
        do_load(100, 2, 1, 0, 0);
        do_load(2000, 1, 1, 0, 0);
        do_fetch(100); do_fetch(101); tick();

        load_start = 1;
        load_base  = 0;
        tick();
        load_start = 0;
        load_valid = 1;
        load_data  = 32'h1111;
        tick();
        load_data  = 32'h2222;
        tick();
        load_valid = 0;
        rst = 1;
        #1;
        chk("midload reset busy", 32'(busy), 1);
        chk("midload reset load_ready", 32'(load_ready), 0);
        chk("midload reset load_done", 32'(load_done), 0);
        chk("midload reset load_overflow", 32'(load_overflow), 0);
        chk("midload reset fetch_valid", 32'(fetch_valid), 0);
        chk("midload reset fetch_ins", fetch_ins, 0);
        chk("midload reset fetch_fault", 32'(fetch_fault), 0);
        tick(); tick();
        rst = 0;
        boot_wait();
        do_fetch(0); do_fetch(1); tick();

        do_load(2, 1, 1, 32'h55, 1);
        do_fetch(2); tick();

        repeat (150) begin
            int r, n;
            logic [31:0] base;
            bit ul;
            r = $urandom_range(9);
            if (r < 6) begin
                do_fetch($urandom_range(7) == 0 ? $urandom : $urandom_range(DEPTH - 1));
                if ($urandom_range(1) == 1) tick();
            end else if (r < 9) begin
                base = $urandom_range(1) == 1 ? DEPTH - 1 - $urandom_range(4) : $urandom_range(DEPTH - 1);
                n = $urandom_range(1, 5);
                ul = (DEPTH - int'(base)) <= n ? 1'($urandom_range(1)) : 1'b1;
                do_load(base, n, ul, 0, 1'($urandom_range(1)));
            end else begin
                do_load(DEPTH + $urandom_range(5000), 1, 1, 0, 0);
            end
        end

        tick(); tick(); tick();
        chk("scoreboard drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
Parametrised word-addressed instruction memory with a built-in boot sequencer and a streaming program-load port.
- After reset, the block rewrites the whole array from a boot image and zero-fill.
- It then serves registered instruction fetches to the CPU front end.
- It accepts runtime program images from a loader, such as a UART or testbench, through a valid/ready handshake.

Parameters:
DATA_W, 32, instruction width in bits
DEPTH, 1024, number of words; power of two
ADDR_W, 32, width of fetch_addr and load_base (word address, not byte)
BOOT_LEN, 6, number of boot-image words taken from the package (must be <= DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
fetch_req  in  1  fetch request, sampled only when busy=0
fetch_addr  in  ADDR_W  word address of the fetch
fetch_valid  out  1  fetch result valid, one cycle after an accepted fetch_req
fetch_ins  out  DATA_W  fetched instruction
fetch_fault  out  1  fetch address >= DEPTH, qualified by fetch_valid
busy  out  1  high during BOOT or LOAD; fetches are ignored while high
load_start  in  1  begin a load at load_base; honoured only in IDLE
load_base  in  ADDR_W  first write address of the load
load_valid  in  1  load word present
load_data  in  DATA_W  load word
load_last  in  1  marks the final word, qualified by load_valid
load_ready  out  1  high only in LOAD
load_done  out  1  one-cycle pulse when a load ends
load_overflow  out  1  sticky; cleared by the next accepted load_start

Behaviour:
- Reset (async assert) values:
  - fetch_valid=0, fetch_ins=0, fetch_fault=0.
  - load_ready=0, load_done=0, load_overflow=0.
  - busy=1, state=BOOT, boot pointer=0.
  - The array itself is not reset; BOOT rewrites it.
- States: BOOT -> IDLE -> LOAD -> IDLE. Reset from any state, including mid-LOAD, returns to BOOT.
- BOOT:
  - One write per clock, pointer i = 0..DEPTH-1.
  - Writes BOOT_IMAGE[i] for i < BOOT_LEN, otherwise 0.
  - After writing DEPTH-1, go to IDLE and drop busy on the next cycle (busy high for exactly DEPTH cycles after reset release).
  - fetch_req and load_start are ignored in BOOT.
- Fetch (IDLE only):
  - fetch_req in cycle N -> fetch_valid=1 in cycle N+1.
  - If fetch_addr < DEPTH: fetch_ins = mem[fetch_addr[log2(DEPTH)-1:0]], fetch_fault=0.
  - If fetch_addr >= DEPTH: fetch_ins = NOP (all zeros), fetch_fault=1.
  - Back-to-back fetches give one result per cycle.
  - Without fetch_req, fetch_valid=0 and fetch_ins/fetch_fault hold their last values.
- load_start in IDLE:
  - Latch ptr = load_base, clear load_overflow, enter LOAD next cycle.
  - If fetch_req arrives in the same cycle, the fetch is serviced normally and reads pre-load contents.
  - If load_base >= DEPTH: load_overflow=1, load_done pulse, stay IDLE.
- LOAD:
  - load_ready=1, busy=1.
  - Each cycle with load_valid && load_ready: mem[ptr] <= load_data, ptr++.
  - Accepted word with load_last=1: return to IDLE, load_done=1 for one cycle.
  - Accepted word at ptr == DEPTH-1 with load_last=0: write it, set load_overflow=1, pulse load_done, return to IDLE. Further words see load_ready=0. No wrap-around.
  - load_valid=0 stalls indefinitely; there is no timeout.
  - load_start is ignored while in LOAD.
- A write and a fetch never coincide, because fetches are blocked while busy. Read-during-write ordering is therefore undefined and needs no handling.

Decomposition:
Package imem_pkg holds:
- State enum {BOOT, IDLE, LOAD}.
- NOP_INS = 32'h0.
- BOOT_IMAGE constant array, default contents: 0x44010000, 0x8C200004, 0x00411001, 0x08210001, 0x83FFFFFD, 0x90000000 (summation program).

One sub-module: imem_array, a 1R1W RAM with synchronous read and synchronous write, parametrised by DATA_W and DEPTH. imem_ctrl holds the FSM, pointers and handshake logic.

Test Plan:
1. Release rst -> busy=1 for 1024 cycles. Then fetch addr 0 -> next cycle fetch_ins=0x44010000; addr 5 -> 0x90000000; addr 6 -> 0; fetch_fault=0 throughout.
2. Fetch addr 1024, then addr 0xFFFFFFFF -> fetch_valid=1, fetch_fault=1, fetch_ins=0 for each. Back-to-back fetches of addrs 0..5 -> six consecutive valid results.
3. Load base 16, words 0xA, 0xB, 0xC with last on 0xC and one idle load_valid=0 cycle between them -> load_done pulse once, busy drops. Fetch 16/17/18 -> 0xA/0xB/0xC.
4. Load base 1022 with four words, last never asserted -> 1022/1023 written, load_overflow=1, load_ready=0 after the second word, third word not accepted. Fetch 1023 -> second word.
5. Assert rst after two words of a load at base 0 -> outputs return to reset values immediately, BOOT reruns, and fetch 0/1 afterwards return 0x44010000/0x8C200004.
6. fetch_req addr 2 and load_start base 2 in the same cycle, then load 0x55 with last -> fetch returns 0x00411001; a later fetch 2 returns 0x55.
